// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_pkg
//  Description : Shared types and constants for the two-master Wishbone
//                memory arbiter (FSM state encoding, grant encodings).
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    // Arbiter ownership state; explicit two-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // One-hot grant encodings presented on grant_o.
    localparam logic [1:0] c_GRANT_NONE = 2'b00;
    localparam logic [1:0] c_GRANT_M0   = 2'b01;
    localparam logic [1:0] c_GRANT_M1   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/wb_arb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_watchdog
//  Description : Per-transfer acknowledge watchdog. Counts cycles of owner
//                strobe without a slave ack and emits a one-cycle registered
//                err pulse when TIMEOUT cycles elapse. TIMEOUT=0 disables it.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arb_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic busy,
    input  logic ack,
    output logic err
);

    localparam int c_CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = {c_CNT_W{1'b1}};
    localparam bit                 c_ENABLE   = (TIMEOUT > 0);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    // Wait counter: ack wins over a coinciding timeout; counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (clr || !busy || ack) begin
                r_cnt <= '0;
            end else if (c_ENABLE && (r_cnt == c_CNT_LAST)) begin
                r_err <= 1'b1;
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign err = r_err;

endmodule
`default_nettype wire

// File: rtl/wb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_mem_arbiter
//  Description : Two-master round-robin Wishbone arbiter in front of the
//                single-port SRAM slave. Grant is held for the owner's whole
//                cyc burst, ack is routed only to the owner, and a watchdog
//                returns err when the slave never acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int AW      = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    // master 0 (CPU data port)
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    // master 1 (DMA / housekeeping)
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    // slave side
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i,
    // current owner
    output logic [1:0]    grant_o
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last;       // 1: master 1 was granted most recently
    logic       w_owner_stb;
    logic       w_err;
    logic       w_state_chg;

    // Next-state: round-robin on simultaneous requests, no mid-burst preemption.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = r_last ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = OWN0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt = m1_cyc_i ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt = m0_cyc_i ? OWN0 : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and last-owner pointer, updated on each entry into OWNx.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                if (w_state_nxt == OWN0) begin
                    r_last <= 1'b0;
                end else if (w_state_nxt == OWN1) begin
                    r_last <= 1'b1;
                end
            end
        end
    end

    // Request mux: owner drives the slave; strobe is suppressed in the err cycle.
    always_comb begin
        s_cyc_o     = 1'b0;
        s_stb_o     = 1'b0;
        s_we_o      = 1'b0;
        s_sel_o     = 4'h0;
        s_adr_o     = '0;
        s_dat_o     = 32'h0;
        grant_o     = c_GRANT_NONE;
        w_owner_stb = 1'b0;
        case (r_state)
            OWN0: begin
                s_cyc_o     = m0_cyc_i;
                s_stb_o     = m0_stb_i & ~w_err;
                s_we_o      = m0_we_i;
                s_sel_o     = m0_sel_i;
                s_adr_o     = m0_adr_i;
                s_dat_o     = m0_dat_i;
                grant_o     = c_GRANT_M0;
                w_owner_stb = m0_stb_i;
            end
            OWN1: begin
                s_cyc_o     = m1_cyc_i;
                s_stb_o     = m1_stb_i & ~w_err;
                s_we_o      = m1_we_i;
                s_sel_o     = m1_sel_i;
                s_adr_o     = m1_adr_i;
                s_dat_o     = m1_dat_i;
                grant_o     = c_GRANT_M1;
                w_owner_stb = m1_stb_i;
            end
            default: ;
        endcase
    end

    assign w_state_chg = (w_state_nxt != r_state);

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .clr  (w_state_chg),
        .busy (w_owner_stb),
        .ack  (s_ack_i),
        .err  (w_err)
    );

    // Read data is broadcast; ack/err qualify it per master.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & (r_state == OWN0) & m0_stb_i;
    assign m1_ack_o = s_ack_i & (r_state == OWN1) & m1_stb_i;
    assign m0_err_o = w_err & (r_state == OWN0);
    assign m1_err_o = w_err & (r_state == OWN1);

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_mem_arbiter
//  Description : Directed self-checking bench for wb_mem_arbiter with a
//                behavioural mem_wb slave (write ack +1, read ack +2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_mem_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
    logic [3:0]  m0_sel_i = 4'h0;
    logic [31:0] m0_adr_i = 32'h0, m0_dat_i = 32'h0;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
    logic [3:0]  m1_sel_i = 4'h0;
    logic [31:0] m1_adr_i = 32'h0, m1_dat_i = 32'h0;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic [1:0]  grant_o;

    int n_total = 0;
    int n_bad   = 0;

    wb_mem_arbiter #(.TIMEOUT(15), .AW(32)) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
        .m0_sel_i (m0_sel_i), .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
        .m1_sel_i (m1_sel_i), .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),  .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .grant_o  (grant_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Behavioural slave: write ack one cycle after strobe, read ack two cycles after.
    logic [31:0] mem [256];
    logic        mdl_ack   = 1'b0;
    logic        mdl_pend  = 1'b0;
    logic        mdl_hold  = 1'b0;
    logic        frc_ack   = 1'b0;
    logic [7:0]  mdl_padr  = 8'h0;
    logic [31:0] mdl_rdata = 32'h0;

    always @(posedge wb_clk_i) begin
        mdl_ack <= 1'b0;
        if (mdl_pend) begin
            mdl_pend  <= 1'b0;
            mdl_ack   <= 1'b1;
            mdl_rdata <= mem[mdl_padr];
        end else if (s_cyc_o && s_stb_o && !mdl_ack && !mdl_hold) begin
            if (s_we_o) begin
                mem[s_adr_o[9:2]] <= s_dat_o;
                mdl_ack <= 1'b1;
            end else begin
                mdl_pend <= 1'b1;
                mdl_padr <= s_adr_o[9:2];
            end
        end
    end

    assign s_ack_i = mdl_ack | frc_ack;
    assign s_dat_i = mdl_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] bh_adr [4] = '{32'h10, 32'h20, 32'h40, 32'h44};
    logic [31:0] bh_exp [4] = '{32'hDEADBEEF, 32'h12345678, 32'hA5A50000, 32'h5A5A1111};

    initial begin
        int k, guard, nrd, npulse;
        logic [1:0] prev;
        logic m0_drop, m1_drop, got;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8] = 32'h12345678;  // word at 0x20

        // ---------------- reset and idle ----------------
        repeat (3) @(negedge wb_clk_i);
        check("rst_grant", grant_o, 2'b00);
        wb_rst_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge wb_clk_i);
            check("idle_ctl", {grant_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o,
                               m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
            check("idle_adr_dat", {s_adr_o, s_dat_o}, 0);
        end
        check("idle_rdat", m0_dat_o, mdl_rdata);

        // ---------------- simultaneous first requests ----------------
        @(negedge wb_clk_i);
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
        m0_adr_i = 32'h10; m0_dat_i = 32'hDEADBEEF;
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_sel_i = 4'hF; m1_adr_i = 32'h20;
        check("sim_c0_grant", grant_o, 2'b00);
        @(negedge wb_clk_i);
        check("sim_c1_grant", grant_o, 2'b01);
        check("sim_c1_req", {s_cyc_o, s_stb_o, s_we_o, s_adr_o}, {3'b111, 32'h10});
        check("sim_c1_wdat", s_dat_o, 32'hDEADBEEF);
        check("sim_c1_ack", m0_ack_o, 1'b0);
        @(negedge wb_clk_i);
        check("sim_c2_acks", {m0_ack_o, m1_ack_o}, 2'b10);
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        @(negedge wb_clk_i);
        check("sim_c3_grant", grant_o, 2'b10);
        check("sim_c3_req", {s_we_o, s_adr_o}, {1'b0, 32'h20});
        check("sim_c3_ack", m1_ack_o, 1'b0);
        @(negedge wb_clk_i);
        check("sim_c4_ack", m1_ack_o, 1'b0);
        @(negedge wb_clk_i);
        check("sim_c5_acks", {m0_ack_o, m1_ack_o}, 2'b01);
        check("sim_c5_rdat", m1_dat_o, 32'h12345678);
        m1_cyc_i = 0; m1_stb_i = 0;
        @(negedge wb_clk_i);
        check("sim_c6_grant", grant_o, 2'b00);

        // ---------------- round-robin fairness ----------------
        m0_we_i = 1; m0_adr_i = 32'h40; m0_dat_i = 32'hA5A50000;
        m1_we_i = 1; m1_adr_i = 32'h44; m1_dat_i = 32'h5A5A1111;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        m0_drop = 0; m1_drop = 0; prev = 2'b00; k = 0; guard = 0;
        while (k < 16 && guard < 300) begin
            @(negedge wb_clk_i);
            guard++;
            if (grant_o != prev && grant_o != 2'b00) begin
                check("rr_grant", grant_o, k[0] ? 2'b10 : 2'b01);
                k++;
            end
            prev = grant_o;
            if (m0_drop) begin m0_cyc_i = 1; m0_stb_i = 1; m0_drop = 0; end
            if (m1_drop) begin m1_cyc_i = 1; m1_stb_i = 1; m1_drop = 0; end
            if (m0_ack_o) begin m0_cyc_i = 0; m0_stb_i = 0; m0_drop = 1; end
            if (m1_ack_o) begin m1_cyc_i = 0; m1_stb_i = 0; m1_drop = 1; end
        end
        check("rr_rounds", k, 16);
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        repeat (4) @(negedge wb_clk_i);
        check("rr_idle", grant_o, 2'b00);

        // ---------------- burst hold ----------------
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = bh_adr[0];
        @(negedge wb_clk_i);
        check("bh_first", grant_o, 2'b10);
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 32'h80; m0_dat_i = 32'hCAFEF00D;
        nrd = 0; guard = 0;
        while (nrd < 4 && guard < 60) begin
            @(negedge wb_clk_i);
            guard++;
            check("bh_grant", grant_o, 2'b10);
            check("bh_m0ack", m0_ack_o, 1'b0);
            if (m1_ack_o) begin
                check("bh_rdat", m1_dat_o, bh_exp[nrd]);
                nrd++;
                if (nrd < 4) m1_adr_i = bh_adr[nrd];
                else begin m1_cyc_i = 0; m1_stb_i = 0; end
            end
        end
        check("bh_reads", nrd, 4);
        @(negedge wb_clk_i);
        check("bh_handoff", grant_o, 2'b01);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge wb_clk_i);
            if (m0_ack_o) got = 1;
        end
        check("bh_m0_done", got, 1'b1);
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        repeat (3) @(negedge wb_clk_i);

        // ---------------- watchdog: no ack ----------------
        mdl_hold = 1;
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h30;
        npulse = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge wb_clk_i);
            if (t == 0) check("wd_grant", grant_o, 2'b01);
            check("wd_err", m0_err_o, t == 15);
            check("wd_err_m1", m1_err_o, 1'b0);
            if (m0_err_o) begin
                npulse++;
                check("wd_stb_gate", s_stb_o, 1'b0);
                m0_cyc_i = 0; m0_stb_i = 0;
            end
        end
        check("wd_pulses", npulse, 1);

        // ---------------- watchdog: ack coincides with timeout ----------------
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h34;
        for (int t = 0; t <= 16; t++) begin
            @(negedge wb_clk_i);
            frc_ack = (t == 14);
            #1;
            check("wd2_ack", m0_ack_o, t == 14);
            check("wd2_err", m0_err_o, 1'b0);
            if (t == 15) begin m0_cyc_i = 0; m0_stb_i = 0; end
        end
        frc_ack = 0;
        mdl_hold = 0;
        repeat (2) @(negedge wb_clk_i);

        // ---------------- reset mid-read ----------------
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h20;
        @(negedge wb_clk_i);
        check("rm_stb", {s_cyc_o, s_stb_o}, 2'b11);
        @(negedge wb_clk_i);
        wb_rst_i = 1;
        @(negedge wb_clk_i);
        check("rm_bus_drop", {s_cyc_o, s_stb_o, grant_o}, 4'b0000);
        check("rm_late_ack", {m0_ack_o, m1_ack_o}, 2'b00);
        wb_rst_i = 0;
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h10;
        @(negedge wb_clk_i);
        check("rm_regain", grant_o, 2'b01);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge wb_clk_i);
            if (m0_ack_o) begin
                got = 1;
                check("rm_rdat", m0_dat_o, 32'h12345678);
            end
        end
        check("rm_m0_done", got, 1'b1);
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        repeat (4) @(negedge wb_clk_i);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
